// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between execute stage and data memory.
// Takes the decoder memory word (memi_i/mwe_i) plus the ALU address and rs2 data.
// It runs one req/gnt/rvalid transaction and holds the core stalled until it ends.
// For loads it returns sign- or zero-extended data to write-back.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   memi_i[4]             access request; [3] reserved; [2:0] func3 size/sign code
//   mwe_i                 1 = store, 0 = load
//   addr_i, wdata_i       effective byte address, store data (rs2)
//   stall_o               combinational hold for PC/pipeline
//   rdata_o, done_o       extended load data, one-cycle completion pulse
//   err_o                 one-cycle pulse on misaligned/illegal access (or timeout)
//   m_*                   data-memory request/response port
//
// Optional feature: define LSU_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT_CYCLES.
module lsu_unit #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        memi_i,
    input  logic              mwe_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [3:0]        m_be_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [31:0]       m_wdata_o,
    input  logic              m_gnt_i,
    input  logic              m_rvalid_i,
    input  logic [31:0]       m_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [2:0]        f3;
    logic              illegal_c;
    logic              misalign_c;
    logic [3:0]        be_c;
    logic [31:0]       wlane_c;
    logic [31:0]       shifted_c;
    logic [31:0]       load_ext_c;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // Reserved decoder bit and, in the default build, the timeout limit are not consumed.
    logic unused_ok;
    assign unused_ok = ^{memi_i[3], 8'(TIMEOUT_CYCLES)};

    assign f3 = memi_i[2:0];

    // Hold the core from the request cycle until DONE.
    assign stall_o = ((state_q == S_IDLE) && memi_i[4]) || (state_q == S_REQ) || (state_q == S_WAIT);

    // Legality and alignment of the incoming access.
    always_comb begin
        if (mwe_i) begin
            illegal_c = f3[2] || (f3[1:0] == 2'b11);
        end else begin
            illegal_c = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        misalign_c = ((f3[1:0] == 2'b01) && addr_i[0]) ||
                     ((f3[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    end

    // Byte enables and store lane replication for the incoming access.
    always_comb begin
        be_c    = 4'b1111;
        wlane_c = wdata_i;
        case (f3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_i[1:0];
                wlane_c = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << addr_i[1:0];
                wlane_c = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Select the addressed byte/halfword of the response and extend it.
    always_comb begin
        shifted_c  = m_rdata_i >> {off_q, 3'b000};
        load_ext_c = m_rdata_i;
        case (size_q)
            2'b00:   load_ext_c = {{24{~uns_q & shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   load_ext_c = {{16{~uns_q & shifted_c[15]}}, shifted_c[15:0]};
            default: ;
        endcase
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        req_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (memi_i[4]) begin
                    if (illegal_c || misalign_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        we_d    = mwe_i;
                        size_d  = f3[1:0];
                        uns_d   = f3[2];
                        off_d   = addr_i[1:0];
                        addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = wlane_c;
                    end
                end
            end
            S_REQ: begin
                if (m_gnt_i && m_rvalid_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdata_d = we_q ? 32'd0 : load_ext_c;
                end else if (m_gnt_i) begin
                    state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
`endif
                end else begin
                    req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (m_rvalid_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdata_d = we_q ? 32'd0 : load_ext_c;
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    // Wait counter: restarts on entry to REQ/WAIT, counts while staying there.
    always_comb begin
        cnt_d = 8'd0;
        if (((state_q == S_REQ) || (state_q == S_WAIT)) && (state_d == state_q)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign m_req_o   = req_q;
    assign m_we_o    = we_q;
    assign m_be_o    = be_q;
    assign m_addr_o  = addr_q;
    assign m_wdata_o = wdata_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Testbench for lsu_unit: directed and random accesses against a behavioural model.
module tb_lsu_unit;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        memi_i;
    logic              mwe_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic              stall_o;
    logic [31:0]       rdata_o;
    logic              done_o;
    logic              err_o;
    logic              m_req_o;
    logic              m_we_o;
    logic [3:0]        m_be_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [31:0]       m_wdata_o;
    logic              m_gnt_i;
    logic              m_rvalid_i;
    logic [31:0]       m_rdata_i;

    int checks   = 0;
    int failures = 0;

    lsu_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memi_i     (memi_i),
        .mwe_i      (mwe_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .rdata_o    (rdata_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_be_o     (m_be_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_gnt_i    (m_gnt_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: access width in bytes from func3.
    function automatic int ref_bytes(input bit [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_err(input bit we, input bit [2:0] f3, input bit [31:0] a);
        bit ill;
        int nb;
        if (we) ill = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (ill) return 1'b1;
        nb = ref_bytes(f3);
        return (int'(a % 32'd4) % nb) != 0;
    endfunction

    function automatic bit [3:0] ref_be(input bit [2:0] f3, input bit [31:0] a);
        int nb;
        int off;
        nb  = ref_bytes(f3);
        off = int'(a % 32'd4);
        if (nb == 4) return 4'hF;
        return 4'(((1 << nb) - 1) << off);
    endfunction

    // Byte lane i carries byte (i mod width) of the store data.
    function automatic bit [31:0] ref_wlane(input bit [2:0] f3, input bit [31:0] w);
        bit [31:0] r;
        int nb;
        nb = ref_bytes(f3);
        r  = 32'd0;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = w[(i % nb)*8 +: 8];
        end
        return r;
    endfunction

    function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] m);
        longint v;
        longint span;
        int nb;
        nb = ref_bytes(f3);
        if (nb == 4) return m;
        span = longint'(1) << (8 * nb);
        v = longint'(m >> (8 * int'(a % 32'd4))) % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // One complete core access with given grant and response delays.
    task automatic do_access(input bit [4:0] memi, input bit we, input bit [31:0] a,
                             input bit [31:0] wd, input bit [31:0] mem_word,
                             input int gnt_dly, input int rv_dly, input string nm);
        bit        e;
        bit [3:0]  be;
        bit [31:0] wl;
        bit [31:0] rd;
        e  = ref_err(we, memi[2:0], a);
        be = ref_be(memi[2:0], a);
        wl = ref_wlane(memi[2:0], wd);
        rd = (e || we) ? 32'd0 : ref_load(memi[2:0], a, mem_word);

        @(posedge clk); #1;
        memi_i = memi; mwe_i = we; addr_i = a; wdata_i = wd;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = $urandom;
        @(negedge clk);
        check({nm, ".issue_stall"}, 32'(stall_o), 32'd1);
        check({nm, ".issue_req"}, 32'(m_req_o), 32'd0);

        if (!e) begin
            for (int k = 0; k <= gnt_dly; k++) begin
                @(posedge clk); #1;
                m_gnt_i    = (k == gnt_dly);
                m_rvalid_i = (k == gnt_dly) ? (rv_dly == 0) : 1'($urandom_range(0, 1));
                m_rdata_i  = (k == gnt_dly && rv_dly == 0) ? mem_word : $urandom;
                @(negedge clk);
                check({nm, ".req"}, 32'(m_req_o), 32'd1);
                check({nm, ".req_stall"}, 32'(stall_o), 32'd1);
                check({nm, ".addr"}, m_addr_o, {a[31:2], 2'b00});
                check({nm, ".be"}, 32'(m_be_o), 32'(be));
                check({nm, ".we"}, 32'(m_we_o), 32'(we));
                if (we) check({nm, ".wdata"}, m_wdata_o, wl);
            end
            for (int j = 1; j <= rv_dly; j++) begin
                @(posedge clk); #1;
                m_gnt_i    = 1'b0;
                m_rvalid_i = (j == rv_dly);
                m_rdata_i  = (j == rv_dly) ? mem_word : $urandom;
                @(negedge clk);
                check({nm, ".wait_req"}, 32'(m_req_o), 32'd0);
                check({nm, ".wait_stall"}, 32'(stall_o), 32'd1);
                check({nm, ".wait_done"}, 32'(done_o), 32'd0);
            end
        end

        // DONE cycle: request still presented but must not be accepted; stray rvalid ignored.
        @(posedge clk); #1;
        m_gnt_i = 1'b0; m_rvalid_i = 1'($urandom_range(0, 1)); m_rdata_i = $urandom;
        @(negedge clk);
        check({nm, ".done"}, 32'(done_o), 32'd1);
        check({nm, ".err"}, 32'(err_o), 32'(e));
        check({nm, ".rdata"}, rdata_o, rd);
        check({nm, ".done_stall"}, 32'(stall_o), 32'd0);
        check({nm, ".done_req"}, 32'(m_req_o), 32'd0);

        @(posedge clk); #1;
        memi_i = 5'd0; m_rvalid_i = 1'b0;
        @(negedge clk);
        check({nm, ".post_done"}, 32'(done_o), 32'd0);
        check({nm, ".post_err"}, 32'(err_o), 32'd0);
        check({nm, ".post_stall"}, 32'(stall_o), 32'd0);
        check({nm, ".post_req"}, 32'(m_req_o), 32'd0);
    endtask

    task automatic check_quiet(input string nm);
        check({nm, ".stall"}, 32'(stall_o), 32'd0);
        check({nm, ".req"}, 32'(m_req_o), 32'd0);
        check({nm, ".done"}, 32'(done_o), 32'd0);
        check({nm, ".err"}, 32'(err_o), 32'd0);
        check({nm, ".rdata"}, rdata_o, 32'd0);
        check({nm, ".we"}, 32'(m_we_o), 32'd0);
        check({nm, ".be"}, 32'(m_be_o), 32'd0);
        check({nm, ".addr"}, m_addr_o, 32'd0);
        check({nm, ".wdata"}, m_wdata_o, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        memi_i = 5'd0; mwe_i = 1'b0; addr_i = '0; wdata_i = 32'd0;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;

        // Directed cases.
        do_access(5'b10010, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1, "lw");
        do_access(5'b10000, 1'b0, 32'h103, 32'd0, 32'h80FFFF00, 0, 1, "lb");
        do_access(5'b10100, 1'b0, 32'h103, 32'd0, 32'h80FFFF00, 0, 1, "lbu");
        do_access(5'b10001, 1'b1, 32'h202, 32'h1234ABCD, 32'd0, 0, 1, "sh");
        do_access(5'b10010, 1'b0, 32'h101, 32'd0, 32'd0, 0, 1, "lw_mis");
        do_access(5'b10010, 1'b0, 32'h204, 32'd0, 32'hCAFEF00D, 5, 1, "lw_gnt5");
        do_access(5'b10101, 1'b0, 32'h306, 32'd0, 32'h8001_7FFF, 0, 0, "lhu_same");
        do_access(5'b10001, 1'b0, 32'h302, 32'd0, 32'h8001_7FFF, 1, 3, "lh_hi");
        do_access(5'b10000, 1'b1, 32'h401, 32'h000000A5, 32'd0, 2, 2, "sb");
        do_access(5'b10011, 1'b1, 32'h400, 32'd0, 32'd0, 0, 1, "st_ill");
        do_access(5'b10110, 1'b0, 32'h400, 32'd0, 32'd0, 0, 1, "ld_ill");
        do_access(5'b11010, 1'b0, 32'h408, 32'd0, 32'h0BADF00D, 0, 1, "lw_rsvd");

        // Reset while waiting for the response.
        @(posedge clk); #1;
        memi_i = 5'b10010; mwe_i = 1'b0; addr_i = 32'h40;
        @(posedge clk); #1;
        m_gnt_i = 1'b1;
        @(posedge clk); #1;
        m_gnt_i = 1'b0;
        @(negedge clk);
        check("rst_wait.stall", 32'(stall_o), 32'd1);
        check("rst_wait.req", 32'(m_req_o), 32'd0);
        #2;
        rst_n = 1'b0; memi_i = 5'd0;
        #1;
        check_quiet("rst_wait.async");
        @(posedge clk); #1;
        rst_n = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 32'h12345678;
        @(negedge clk);
        check("rst_late.done0", 32'(done_o), 32'd0);
        @(posedge clk); #1;
        m_rvalid_i = 1'b0;
        @(negedge clk);
        check("rst_late.done1", 32'(done_o), 32'd0);
        check("rst_late.err", 32'(err_o), 32'd0);
        check("rst_late.rdata", rdata_o, 32'd0);

        // Random accesses, including illegal codes and misaligned addresses.
        repeat (200) begin
            bit [2:0]  f3;
            bit        we;
            bit [31:0] a;
            f3 = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            a  = $urandom;
            do_access({1'b1, 1'($urandom_range(0, 1)), f3}, we, a, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit that consumes the main decoder's memory control word (`memi`, `mwe`) together with the ALU-computed address and the rs2 data.
- Runs a req/gnt/rvalid transaction on the data-memory port and stalls the core for its duration.
- Delivers sign- or zero-extended load data to the register-file write-back mux.
- Sits between the execute stage and data memory; `stall_o` gates `enpc`.

Parameters:
- ADDR_W, 32, address width on core and memory sides.
- TIMEOUT_CYCLES, 16, max cycles waiting for gnt or rvalid before abort (used only with the optional feature).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- memi_i  input  5  decoder memory word: bit4 = access request, bit3 reserved (ignored), [2:0] = RISC-V func3 size/sign code.
- mwe_i  input  1  1 = store, 0 = load; valid only when memi_i[4] = 1.
- addr_i  input  ADDR_W  effective byte address.
- wdata_i  input  32  store data (rs2).
- stall_o  output  1  1 = hold PC/pipeline; core must keep inputs stable while high.
- rdata_o  output  32  extended load result; valid in the cycle done_o = 1.
- done_o  output  1  one-cycle pulse marking transaction completion.
- err_o  output  1  one-cycle pulse on misaligned or illegal access (and on timeout with the optional feature).
- m_req_o  output  1  memory request.
- m_we_o  output  1  memory write enable.
- m_be_o  output  4  byte enables.
- m_addr_o  output  ADDR_W  word-aligned address (addr_i with [1:0] forced to 0).
- m_wdata_o  output  32  store data replicated into byte lanes.
- m_gnt_i  input  1  memory accepted the request.
- m_rvalid_i  input  1  response valid; rdata valid for loads, write acknowledge for stores.
- m_rdata_i  input  32  memory read word.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE
  - If memi_i[4] = 0: stay in IDLE, stall_o = 0.
  - If memi_i[4] = 1: stall_o = 1 combinationally in the same cycle.
  - If the access is illegal or misaligned: go to DONE with the error flag set; no m_req_o is issued.
  - Otherwise: latch addr, size, we and wdata, then go to REQ.
- Illegal codes:
  - Loads: func3 in {011, 110, 111}.
  - Stores: func3 not in {000, 001, 010}.
- Misaligned accesses: halfword with addr[0] = 1; word with addr[1:0] != 0.
- REQ
  - m_req_o = 1; m_we_o, m_be_o, m_addr_o and m_wdata_o are driven from latched values and held stable.
  - Stay until m_gnt_i = 1, then go to WAIT.
  - If m_gnt_i and m_rvalid_i are both 1 in the same cycle, go directly to DONE.
- WAIT
  - m_req_o = 0.
  - On m_rvalid_i = 1: capture m_rdata_i and go to DONE.
- DONE (exactly one cycle)
  - stall_o = 0 and done_o = 1.
  - rdata_o is valid for loads; for stores and errors rdata_o = 0.
  - err_o = 1 if the error flag is set.
  - Next state is IDLE.
  - A new memi_i[4] request is not accepted in the DONE cycle; it is accepted on the following IDLE cycle.
- Byte enables:
  - Byte access: 0001 << addr[1:0].
  - Halfword access: 0011 << addr[1:0].
  - Word access: 1111.
- Store lane data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction: select the byte or halfword using addr[1:0].
  - 000: sign-extend byte.
  - 100: zero-extend byte.
  - 001: sign-extend halfword.
  - 101: zero-extend halfword.
  - 010: full word.
- Latency with zero-wait memory (gnt in REQ, rvalid one cycle later): request cycle, REQ, WAIT, DONE, giving 3 stalled cycles.
- Reset asserted in any state: immediate return to IDLE, m_req_o = 0, and no done_o/err_o pulse.
- m_rvalid_i arriving outside WAIT (or outside the REQ same-cycle case) is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears when entering REQ or WAIT and increments each cycle spent in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES - 1 without the awaited gnt/rvalid, the FSM goes to DONE with the error flag set and m_req_o drops.
  - A late rvalid arriving after the abort is ignored.
- Undefined: no counter; REQ and WAIT wait indefinitely.

Test Plan:
- LW, addr 0x100, m_gnt_i immediate, rvalid next cycle with m_rdata_i 0xDEADBEEF:
  - m_be_o = 1111, m_addr_o = 0x100, stall_o high for 3 cycles.
  - Then done_o = 1 with rdata_o = 0xDEADBEEF.
- LB at 0x103 with m_rdata_i 0x80FF_FF00 -> rdata_o = 0xFFFFFF80; LBU at the same address -> rdata_o = 0x00000080.
- SH, addr 0x202, wdata 0x1234ABCD:
  - m_we_o = 1, m_be_o = 1100, m_wdata_o = 0xABCDABCD.
  - done_o on rvalid, err_o = 0.
- LW at 0x101 -> no m_req_o; err_o = 1 and done_o = 1 one cycle later; stall_o released.
- m_gnt_i held low for 5 cycles -> m_req_o stays high with m_addr_o/m_be_o stable for all 5 cycles, then completes normally.
  - With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4 -> err_o pulses after 4 REQ cycles.
- rst_n pulsed low while in WAIT -> outputs return to 0 immediately; a subsequent rvalid produces no done_o.
